conv_window_3x3: RTL and testbench
==================================

# conv_window_3x3

Streaming 3x3 sliding-window builder for the HLS convolution path. It sits directly downstream of the BRAM line-delay shift registers. Each cycle it takes the current pixel plus the two row-delayed taps from those line delays, all column-aligned. It assembles a 3x3 window, tracks raster position, and emits a window valid for every interior window centre of an IMG_W x IMG_H frame.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 256, frame width in pixels; must be at least 3
- IMG_H, 256, frame height in pixels; must be at least 3
- ap_clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel strobe; must stay high for IMG_W*IMG_H consecutive cycles per frame
- in_pixel  in  DATA_W  current pixel (r,c)
- tap_row1  in  DATA_W  pixel (r-1,c) from the first line delay
- tap_row2  in  DATA_W  pixel (r-2,c) from the second line delay
- win_valid  out  1  window output qualifier
- win  out  9*DATA_W  window; element (wr,wc) sits at bits [(wr*3+wc)*DATA_W +: DATA_W]; wr=0 is the top (oldest) row, wc=0 is the left (oldest) column
- win_row  out  16  centre row of the current window
- win_col  out  16  centre column of the current window
- frame_done  out  1  one-cycle pulse at the end of a complete frame
- err_abort  out  1  one-cycle pulse when a frame is aborted
- win_count  out  16  windows emitted in the current frame (see Configuration)

## Operation
- FSM states are IDLE and RUN. Column counter col is 0..IMG_W-1; row counter row is 0..IMG_H-1.
- IDLE with in_valid=1: the pixel is (0,0). Shift the window, set col=1 and row=0, go to RUN.
- RUN with in_valid=1:
  - Shift the window left: column 0 takes column 1, column 1 takes column 2, column 2 takes {tap_row2, tap_row1, in_pixel} for rows 0/1/2.
  - Advance col. At IMG_W-1, col wraps to 0 and row increments.
- Window emission: for the accepted pixel (r,c) with r>=2 and c>=2:
  - next cycle win_valid=1, win_row=r-1, win_col=c-1.
  - Otherwise win_valid=0. Columns carried across a row wrap are stale, so c>=2 masks them.
- Frame end: on the accepted pixel (IMG_H-1,IMG_W-1), the next cycle asserts frame_done=1 together with the last win_valid. Counters clear and the FSM returns to IDLE.
- Back-to-back frames: in_valid=1 on the cycle right after the last pixel starts a new frame at (0,0) with no bubble.
- Abort: in_valid=0 while in RUN means the next cycle has err_abort=1 and win_valid=0. Counters clear and the FSM returns to IDLE. The partial frame is discarded and no frame_done is issued.
- Tap values for r<2 are don't-care; they are never part of an emitted window.
- Per frame, exactly (IMG_H-2)*(IMG_W-2) windows are emitted.

## Timing
- Reset values: win_valid=0, win=0, win_row=0, win_col=0, frame_done=0, err_abort=0, win_count=0. FSM is IDLE and counters are 0.
- Latency from the accepted pixel to the window containing it as its bottom-right element: 1 cycle, with all outputs registered.
- Throughput: one window per cycle in steady state, with no backpressure. Downstream must accept every win_valid.
- Reset asserted mid-frame clears everything immediately. The next in_valid after release is treated as pixel (0,0).
- Outputs hold their last value when win_valid=0, except the pulses frame_done and err_abort, which are 0.

## Configuration
- CONV_WIN3X3_COUNT_EN defined:
  - win_count increments on each emitted window and saturates at 16'hFFFF.
  - It clears to 0 in the cycle after frame_done or err_abort, and holds its final value during the frame_done cycle.
- Not defined: win_count is tied to 0 and the counter logic is absent.

## Test plan
- IMG_W=4, IMG_H=4, in_pixel=r*4+c, taps driven from a bench line-delay model:
  - 4 windows at centres (1,1),(1,2),(2,1),(2,2).
  - The (1,1) window is {0,1,2,4,5,6,8,9,10}; the (2,2) window is {5,6,7,9,10,11,13,14,15}.
  - frame_done coincides with the (2,2) window.
- Reset: hold reset_n=0 for 3 cycles, then check that all outputs are 0. Release reset_n and check no win_valid appears without in_valid.
- Back-to-back: 2 frames of 4x4 with in_valid continuous for 32 cycles produce 8 windows, 2 frame_done pulses, and correct centres in the second frame.
- Abort: drop in_valid at pixel (2,3) of the first frame:
  - err_abort pulses once, with no frame_done.
  - A following full frame yields the normal 4 windows.
- Row wrap: IMG_W=5, IMG_H=3 gives windows only at centres (1,1),(1,2),(1,3). No window is emitted while the columns are stale after the wrap.
- CONV_WIN3X3_COUNT_EN defined with a 4x4 frame: win_count reads 4 at frame_done and 0 on the following cycle. With the macro undefined it stays at 0 throughout.

Source files
------------

// File: rtl/conv_window_3x3.sv
// Streaming 3x3 sliding-window builder fed by two column-aligned line-delay taps.
// Optional CONV_WIN3X3_COUNT_EN adds a saturating per-frame window counter on win_count.
module conv_window_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
) (
    input  logic                ap_clk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_pixel,
    input  logic [DATA_W-1:0]   tap_row1,
    input  logic [DATA_W-1:0]   tap_row2,
    output logic                win_valid,
    output logic [9*DATA_W-1:0] win,
    output logic [15:0]         win_row,
    output logic [15:0]         win_col,
    output logic                frame_done,
    output logic                err_abort,
    output logic [15:0]         win_count
);

    localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                r_state;
    logic [15:0]           r_col;
    logic [15:0]           r_row;
    logic [9*DATA_W-1:0]   r_sr;
    logic                  r_win_valid;
    logic [9*DATA_W-1:0]   r_win;
    logic [15:0]           r_win_row;
    logic [15:0]           r_win_col;
    logic                  r_frame_done;
    logic                  r_err_abort;

    logic [3*DATA_W-1:0]   w_col_in;
    logic [9*DATA_W-1:0]   w_sr_next;
    logic                  w_emit;
    logic                  w_last;

    // Incoming column, indexed by window row: row 0 is the oldest line.
    assign w_col_in = {in_pixel, tap_row1, tap_row2};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            assign w_sr_next[(gi*3+0)*DATA_W +: DATA_W] = r_sr[(gi*3+1)*DATA_W +: DATA_W];
            assign w_sr_next[(gi*3+1)*DATA_W +: DATA_W] = r_sr[(gi*3+2)*DATA_W +: DATA_W];
            assign w_sr_next[(gi*3+2)*DATA_W +: DATA_W] = w_col_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Columns carried over a row wrap are stale until two new pixels arrive.
    assign w_emit = (r_state == S_RUN) && in_valid && (r_row >= 16'd2) && (r_col >= 16'd2);
    assign w_last = (r_state == S_RUN) && in_valid && (r_row == LAST_ROW) && (r_col == LAST_COL);

    always_ff @(posedge ap_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_sr         <= '0;
            r_win_valid  <= 1'b0;
            r_win        <= '0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
            r_err_abort  <= 1'b0;
        end else begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_abort  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sr    <= w_sr_next;
                        r_col   <= 16'd1;
                        r_row   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        r_sr <= w_sr_next;
                        if (w_emit) begin
                            r_win_valid <= 1'b1;
                            r_win       <= w_sr_next;
                            r_win_row   <= r_row - 16'd1;
                            r_win_col   <= r_col - 16'd1;
                        end
                        if (w_last) begin
                            r_frame_done <= 1'b1;
                            r_col        <= '0;
                            r_row        <= '0;
                            r_state      <= S_IDLE;
                        end else if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + 16'd1;
                        end else begin
                            r_col <= r_col + 16'd1;
                        end
                    end else begin
                        r_err_abort <= 1'b1;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV_WIN3X3_COUNT_EN
    logic [15:0] r_count;

    // Holds the final total through the frame_done cycle, then clears.
    always_ff @(posedge ap_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (r_frame_done || r_err_abort) begin
            r_count <= '0;
        end else if (w_emit && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign win_count = r_count;
`else
    assign win_count = '0;
`endif

    assign win_valid  = r_win_valid;
    assign win        = r_win;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;
    assign err_abort  = r_err_abort;

endmodule

// File: tb/tb_conv_window_3x3.sv
// Randomized self-checking bench for conv_window_3x3: a frame-level image model predicts
// every window, its centre and its arrival cycle; two instances cover 4x4 and 5x3 frames.
module tb_conv_window_3x3;

    localparam int DW = 8;

    logic          ap_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          drv_valid = 1'b0;
    logic [DW-1:0] pix = '0;
    logic [DW-1:0] t1 = '0;
    logic [DW-1:0] t2 = '0;
    bit            sel = 1'b0;

    logic          iv4, iv5;
    logic          v4, v5, fd4, fd5, ab4, ab5;
    logic [71:0]   w4, w5;
    logic [15:0]   wr4, wr5, wc4, wc5, cnt4, cnt5;

    logic          m_valid, m_done, m_abort;
    logic [71:0]   m_win;
    logic [15:0]   m_row, m_col, m_cnt;

    int            n_vec = 0;
    int            n_err = 0;
    int unsigned   edge_no = 0;
    int unsigned   abort_edge = 32'hFFFF_FFFF;

    typedef struct {
        int unsigned e;
        logic [71:0] w;
        int          r;
        int          c;
        bit          done;
    } exp_t;
    exp_t q[$];

    logic [7:0] img [0:7][0:7];

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) edge_no <= edge_no + 1;

    assign iv4 = drv_valid && !sel;
    assign iv5 = drv_valid && sel;

    conv_window_3x3 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut4 (
        .ap_clk(ap_clk), .reset_n(reset_n), .in_valid(iv4),
        .in_pixel(pix), .tap_row1(t1), .tap_row2(t2),
        .win_valid(v4), .win(w4), .win_row(wr4), .win_col(wc4),
        .frame_done(fd4), .err_abort(ab4), .win_count(cnt4)
    );

    conv_window_3x3 #(.DATA_W(DW), .IMG_W(5), .IMG_H(3)) dut5 (
        .ap_clk(ap_clk), .reset_n(reset_n), .in_valid(iv5),
        .in_pixel(pix), .tap_row1(t1), .tap_row2(t2),
        .win_valid(v5), .win(w5), .win_row(wr5), .win_col(wc5),
        .frame_done(fd5), .err_abort(ab5), .win_count(cnt5)
    );

    assign m_valid = sel ? v5  : v4;
    assign m_win   = sel ? w5  : w4;
    assign m_row   = sel ? wr5 : wr4;
    assign m_col   = sel ? wc5 : wc4;
    assign m_done  = sel ? fd5 : fd4;
    assign m_abort = sel ? ab5 : ab4;
    assign m_cnt   = sel ? cnt5 : cnt4;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    // Per-cycle monitor against the expected-window queue.
    int  mdl_cnt = 0;
    bit  cnt_clr = 1'b0;
    always @(negedge ap_clk) begin
        exp_t e;
        bit   exp_v;
        bit   exp_d;
        bit   exp_a;
        if (!reset_n) begin
            mdl_cnt = 0;
            cnt_clr = 1'b0;
        end else begin
            while (q.size() > 0 && q[0].e < edge_no) begin
                chk("missed_window_edge", 128'(edge_no), 128'(q[0].e));
                void'(q.pop_front());
            end
            exp_v = (q.size() > 0) && (q[0].e == edge_no);
            exp_d = 1'b0;
            exp_a = (abort_edge == edge_no);
            if (cnt_clr) mdl_cnt = 0;
            chk("win_valid", 128'(m_valid), 128'(exp_v));
            if (exp_v) begin
                e = q.pop_front();
                exp_d = e.done;
                mdl_cnt++;
                chk("win", 128'(m_win), 128'(e.w));
                chk("win_row", 128'(m_row), 128'(e.r));
                chk("win_col", 128'(m_col), 128'(e.c));
                chk("frame_done", 128'(m_done), 128'(e.done));
            end else begin
                chk("frame_done_idle", 128'(m_done), 128'(1'b0));
            end
            chk("err_abort", 128'(m_abort), 128'(exp_a));
`ifdef CONV_WIN3X3_COUNT_EN
            chk("win_count", 128'(m_cnt), 128'(mdl_cnt));
`else
            chk("win_count", 128'(m_cnt), 128'(0));
`endif
            cnt_clr = exp_d || exp_a;
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, 128'(m_valid), 128'(0));
        chk({tag, "_win"},   128'(m_win),   128'(0));
        chk({tag, "_row"},   128'(m_row),   128'(0));
        chk({tag, "_col"},   128'(m_col),   128'(0));
        chk({tag, "_done"},  128'(m_done),  128'(0));
        chk({tag, "_abort"}, 128'(m_abort), 128'(0));
        chk({tag, "_count"}, 128'(m_cnt),   128'(0));
    endtask

    task automatic idle(input int n);
        @(posedge ap_clk); #1;
        drv_valid = 1'b0;
        repeat (n - 1) @(posedge ap_clk);
    endtask

    // Streams one frame; abort_at drops in_valid at that pixel, stop_at returns early.
    task automatic drive_frame(input int w, input int h, input bit ramp,
                               input int abort_at, input int stop_at);
        exp_t e;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = ramp ? 8'(r * w + c) : 8'($urandom);
        for (int idx = 0; idx < w * h; idx++) begin
            int r;
            int c;
            r = idx / w;
            c = idx % w;
            if (idx == stop_at) return;
            @(posedge ap_clk); #1;
            if (idx == abort_at) begin
                drv_valid  = 1'b0;
                abort_edge = edge_no + 1;
                return;
            end
            drv_valid = 1'b1;
            pix = img[r][c];
            t1  = (r >= 1) ? img[r-1][c] : 8'($urandom);
            t2  = (r >= 2) ? img[r-2][c] : 8'($urandom);
            if (r >= 2 && c >= 2) begin
                e.e = edge_no + 1;
                e.w = '0;
                for (int wr = 0; wr < 3; wr++)
                    for (int wc = 0; wc < 3; wc++)
                        e.w[(wr*3+wc)*8 +: 8] = img[r-2+wr][c-2+wc];
                e.r = r - 1;
                e.c = c - 1;
                e.done = (r == h - 1) && (c == w - 1);
                q.push_back(e);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check_zero_outputs("reset");
        reset_n = 1'b1;
        idle(5);

        // Ramp frame: windows (1,1)={0,1,2,4,5,6,8,9,10} ... (2,2) with frame_done.
        drive_frame(4, 4, 1'b1, -1, -1);
        idle(3);

        drive_frame(4, 4, 1'b0, -1, -1);
        drive_frame(4, 4, 1'b0, -1, -1);
        idle(3);

        drive_frame(4, 4, 1'b0, 2*4 + 3, -1);
        drive_frame(4, 4, 1'b0, -1, -1);
        idle(3);

        drive_frame(4, 4, 1'b0, -1, 6);
        @(posedge ap_clk); #1;
        reset_n   = 1'b0;
        drv_valid = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check_zero_outputs("midreset");
        q.delete();
        reset_n = 1'b1;
        drive_frame(4, 4, 1'b0, -1, -1);
        idle(3);

        sel = 1'b1;
        drive_frame(5, 3, 1'b1, -1, -1);
        drive_frame(5, 3, 1'b0, -1, -1);
        idle(3);
        drive_frame(5, 3, 1'b0, int'($urandom_range(1, 14)), -1);
        drive_frame(5, 3, 1'b0, -1, -1);
        idle(3);

        sel = 1'b0;
        for (int f = 0; f < 8; f++) begin
            drive_frame(4, 4, 1'b0, ($urandom % 3 == 0) ? int'($urandom_range(1, 15)) : -1, -1);
            if ($urandom % 2) idle(2);
        end
        idle(4);

        chk("queue_empty", 128'(q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
